// File: rtl/pack_det_qualifier.sv
// pack_det_qualifier
//   Turns a stream of per-strobe packet-detect decisions into packet events.
//   A run of MIN_PLATEAU consecutive detect strobes declares a packet (LOCKED).
//   LOSS_CNT consecutive non-detect strobes while locked abandon the packet.
//   A downstream sync_done moves the lock into a HOLDOFF window of
//   HOLDOFF_CYC clocks, after which detection re-arms in IDLE.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   s_RST        synchronous active-high reset
//   enable       qualifier enable; low forces IDLE and clears all counters
//   Pack_det     detect decision, meaningful only when pak_strobe=1
//   pak_strobe   one-cycle qualifier for Pack_det
//   sync_done    one-cycle pulse from timing sync; acted on only in LOCKED
//   pkt_start    one-cycle pulse when a packet is declared
//   pkt_active   high while in LOCKED
//   false_alarm  one-cycle pulse when a candidate or locked packet is dropped
//   plateau_cnt  consecutive-detect count (saturates at 255 while locked)
//   state        IDLE=0, COUNT=1, LOCKED=2, HOLDOFF=3
module pack_det_qualifier #(
  parameter int MIN_PLATEAU = 100,
  parameter int LOSS_CNT    = 16,
  parameter int HOLDOFF_CYC = 320
) (
  input  logic       CLK,
  input  logic       s_RST,
  input  logic       enable,
  input  logic       Pack_det,
  input  logic       pak_strobe,
  input  logic       sync_done,
  output logic       pkt_start,
  output logic       pkt_active,
  output logic       false_alarm,
  output logic [7:0] plateau_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    LOCKED  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0]  MIN_P  = 8'(MIN_PLATEAU);
  localparam logic [7:0]  LOSS_T = 8'(LOSS_CNT);
  // HOLDOFF is left on the clock where the counter reaches this value,
  // giving exactly HOLDOFF_CYC cycles spent in the state.
  localparam logic [15:0] HOLD_T = 16'(HOLDOFF_CYC - 1);

  state_t      st_q, st_d;
  logic [7:0]  cnt_d, cnt_inc, cnt_sat;
  logic [7:0]  loss_q, loss_d, loss_inc;
  logic [15:0] hold_q, hold_d;
  logic        start_d, fa_d;

  assign cnt_inc  = plateau_cnt + 8'd1;
  assign cnt_sat  = (plateau_cnt == 8'hFF) ? 8'hFF : cnt_inc;
  assign loss_inc = loss_q + 8'd1;
  assign state    = st_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = plateau_cnt;
    loss_d  = loss_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    fa_d    = 1'b0;
    if (!enable) begin
      // Silent abort: no pulses, everything back to rest.
      st_d   = IDLE;
      cnt_d  = 8'd0;
      loss_d = 8'd0;
      hold_d = 16'd0;
    end else begin
      case (st_q)
        IDLE: begin
          if (pak_strobe) begin
            if (Pack_det) begin
              st_d  = COUNT;
              cnt_d = 8'd1;
            end else begin
              cnt_d = 8'd0;
            end
          end
        end
        COUNT: begin
          if (pak_strobe) begin
            if (Pack_det) begin
              cnt_d = cnt_inc;
              if (cnt_inc == MIN_P) begin
                st_d    = LOCKED;
                start_d = 1'b1;
              end
            end else begin
              st_d  = IDLE;
              cnt_d = 8'd0;
              fa_d  = 1'b1;
            end
          end
        end
        LOCKED: begin
          // sync_done wins over a same-cycle loss terminal count.
          if (sync_done) begin
            st_d   = HOLDOFF;
            cnt_d  = 8'd0;
            loss_d = 8'd0;
            hold_d = 16'd0;
          end else if (pak_strobe) begin
            if (Pack_det) begin
              cnt_d  = cnt_sat;
              loss_d = 8'd0;
            end else if (loss_inc == LOSS_T) begin
              st_d   = IDLE;
              cnt_d  = 8'd0;
              loss_d = 8'd0;
              fa_d   = 1'b1;
            end else begin
              loss_d = loss_inc;
            end
          end
        end
        HOLDOFF: begin
          if (hold_q == HOLD_T) begin
            st_d   = IDLE;
            hold_d = 16'd0;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (s_RST) begin
      st_q        <= IDLE;
      plateau_cnt <= 8'd0;
      loss_q      <= 8'd0;
      hold_q      <= 16'd0;
      pkt_start   <= 1'b0;
      false_alarm <= 1'b0;
      pkt_active  <= 1'b0;
    end else begin
      st_q        <= st_d;
      plateau_cnt <= cnt_d;
      loss_q      <= loss_d;
      hold_q      <= hold_d;
      pkt_start   <= start_d;
      false_alarm <= fa_d;
      pkt_active  <= (st_d == LOCKED);
    end
  end

endmodule

// File: doc/pack_det_qualifier.md
PACK_DET_QUALIFIER -- requirements
Module: pack_det_qualifier

Interface
REQ-001 Parameter MIN_PLATEAU, default 100: consecutive qualifying strobes needed to declare a packet (range 2..255).
REQ-002 Parameter LOSS_CNT, default 16: consecutive non-detect strobes in LOCKED that abort the packet (range 1..255).
REQ-003 Parameter HOLDOFF_CYC, default 320: clock cycles spent in HOLDOFF after sync_done (range 1..65535).
REQ-004 CLK  input  1  single clock; all logic on the rising edge.
REQ-005 s_RST  input  1  reset, synchronous and active-high.
REQ-006 enable  input  1  qualifier enable; low forces IDLE.
REQ-007 Pack_det  input  1  per-strobe packet-detect decision from the upstream decision stage; valid only when pak_strobe=1.
REQ-008 pak_strobe  input  1  one-cycle qualifier for Pack_det.
REQ-009 sync_done  input  1  one-cycle pulse from downstream timing sync marking the end of preamble processing.
REQ-010 pkt_start  output  1  one-cycle pulse when a packet is declared.
REQ-011 pkt_active  output  1  high while in LOCKED.
REQ-012 false_alarm  output  1  one-cycle pulse when a candidate or locked packet is abandoned.
REQ-013 plateau_cnt  output  8  current consecutive-detect count.
REQ-014 state  output  2  IDLE=0, COUNT=1, LOCKED=2, HOLDOFF=3.

Function
REQ-015 All outputs are registered; all state changes occur only on cycles with pak_strobe=1, except sync_done, enable and HOLDOFF timing.
REQ-016 IDLE: strobe with Pack_det=1 -> COUNT, plateau_cnt=1; strobe with Pack_det=0 -> stay, plateau_cnt=0.
REQ-017 COUNT: strobe with Pack_det=1 increments plateau_cnt; when the incremented value equals MIN_PLATEAU -> LOCKED, with pkt_start=1 for exactly the next cycle.
REQ-018 COUNT: strobe with Pack_det=0 -> IDLE, plateau_cnt=0, false_alarm=1 for one cycle.
REQ-019 LOCKED: pkt_active=1; plateau_cnt keeps incrementing on detect strobes, saturating at 255.
REQ-020 LOCKED: an internal loss counter increments on each strobe with Pack_det=0 and clears on each strobe with Pack_det=1; on reaching LOSS_CNT -> IDLE, false_alarm pulse, plateau_cnt=0.
REQ-021 LOCKED: sync_done=1 -> HOLDOFF, plateau_cnt=0, loss counter cleared; sync_done takes priority over a same-cycle loss terminal count (no false_alarm).
REQ-022 sync_done in IDLE, COUNT or HOLDOFF is ignored.
REQ-023 HOLDOFF: Pack_det/pak_strobe ignored; holdoff counter counts HOLDOFF_CYC cycles, then -> IDLE; pkt_active=0.
REQ-024 pkt_start and false_alarm are never high in the same cycle; each is high for exactly one cycle per event.
REQ-025 enable=0 sampled at an edge -> IDLE next cycle, all counters cleared, no pulses issued; has priority over every transition except s_RST.
REQ-026 pak_strobe on back-to-back cycles is legal; each strobe is processed independently.

Reset
REQ-027 s_RST=1 at an edge -> state=IDLE, pkt_start=0, pkt_active=0, false_alarm=0, plateau_cnt=0, loss and holdoff counters 0, on the following cycle.
REQ-028 s_RST asserted mid-packet (COUNT, LOCKED or HOLDOFF) aborts it with no pkt_start or false_alarm pulse; s_RST has priority over enable and all inputs.

Verification (bench uses MIN_PLATEAU=4, LOSS_CNT=2, HOLDOFF_CYC=5, strobe every 4th cycle, enable=1)
REQ-029 4 consecutive detect strobes -> state 0,1,1,1,2; pkt_start single pulse one cycle after 4th strobe; pkt_active=1; plateau_cnt=4.
REQ-030 Detect, detect, non-detect strobes -> false_alarm single pulse after 3rd strobe, state=IDLE, plateau_cnt=0, no pkt_start.
REQ-031 In LOCKED: non-detect, detect, non-detect, non-detect -> lock held after first loss (counter cleared), IDLE plus false_alarm after 4th strobe.
REQ-032 In LOCKED: sync_done coincident with 2nd consecutive non-detect strobe -> HOLDOFF, no false_alarm; detect strobes during the next 5 cycles ignored; IDLE after 5 cycles.
REQ-033 s_RST pulsed while plateau_cnt=3 in COUNT -> all outputs zero next cycle, no pulses; then 4 detect strobes lock normally.
REQ-034 enable dropped in LOCKED -> IDLE next cycle, pkt_active=0, no false_alarm; strobes ignored while enable=0.
